branch_resolver: RTL and testbench

- Execute-stage consumer of branch predictions. Carries each conditional branch's prediction and its predictor-table index from Decode into Execute.
- Compares the prediction against the resolved outcome and raises a one-cycle redirect with the corrected PC on a mismatch.
- Drives the single-cycle update strobe (enable, taken, index) back to the local predictor table.
- Keeps saturating branch and mispredict counters for performance monitoring.

---
 rtl/branch_pkg.sv | 28 ++
 rtl/sat_counter.sv | 25 ++
 rtl/branch_resolver.sv | 96 +++++++++
 tb/tb_branch_resolver.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types for the branch predictor and the Execute-stage resolver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package branch_pkg;

    // Default width of the local predictor table index.
    localparam int IDX_W_DEF = 8;

    // 2-bit saturating predictor state. The MSB is the taken prediction.
    typedef enum logic [1:0] {
        SU = 2'b00,  // strongly untaken
        WU = 2'b01,  // weakly untaken
        WT = 2'b10,  // weakly taken
        ST = 2'b11   // strongly taken
    } pred_state_t;

    // Update strobe sent from the resolver back to the predictor table.
    typedef struct packed {
        logic                 en;
        logic [IDX_W_DEF-1:0] idx;
        logic                 taken;
    } update_t;

    function automatic logic pred_of(input pred_state_t s);
        return s[1];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Latency: count is registered, visible the cycle after inc/clr.
// Backpressure: none; clr overrides a same-cycle inc.
// Ports: clk_i, reset_i (async, active-high), inc, clr, count[W-1:0].
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Carries branch predictions from Decode to Execute, resolves them, redirects fetch and trains the predictor.
// Latency: redirect and update strobe are combinational from the E register (zero added cycles); counters registered.
// Backpressure: stall_e_i holds the E register and suppresses resolution; flush_e_i invalidates the load.
// Ports: D-side branch info in, E-side outcome/target in, redirect + predictor update + perf counters out.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             stall_e_i,
    input  logic             flush_e_i,
    input  logic             branch_d_i,
    input  logic             pred_taken_d_i,
    input  logic [IDX_W-1:0] pred_idx_d_i,
    input  logic [31:0]      pc_plus4_d_i,
    input  logic             taken_e_i,
    input  logic [31:0]      pc_target_e_i,
    input  logic             cnt_clr_i,
    output logic             redirect_o,
    output logic [31:0]      redirect_pc_o,
    output logic             update_en_o,
    output logic [IDX_W-1:0] update_idx_o,
    output logic             update_taken_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    logic             valid_e;
    logic             pred_e;
    logic [IDX_W-1:0] idx_e;
    logic [31:0]      pc_plus4_e;

    logic    resolve;
    logic    mispredict;
    update_t upd;

    // D->E register. Flush beats stall; flushed entries only need valid cleared.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_e    <= 1'b0;
            pred_e     <= 1'b0;
            idx_e      <= '0;
            pc_plus4_e <= '0;
        end else if (flush_e_i) begin
            valid_e    <= 1'b0;
        end else if (!stall_e_i) begin
            valid_e    <= branch_d_i;
            pred_e     <= pred_taken_d_i;
            idx_e      <= pred_idx_d_i;
            pc_plus4_e <= pc_plus4_d_i;
        end
    end

    // A branch resolves only in the cycle it leaves Execute, so a stalled
    // branch strobes exactly once. Flush does not gate this: it kills the
    // instruction behind, not the one being resolved.
    assign resolve    = valid_e & ~stall_e_i;
    assign mispredict = resolve & (pred_e != taken_e_i);

    // Outcome is masked by valid_e so nothing leaks out while the stage is empty
    // (including during reset).
    always_comb begin
        upd       = '0;
        upd.en    = resolve;
        upd.idx   = idx_e;
        upd.taken = taken_e_i & valid_e;
    end

    assign update_en_o    = upd.en;
    assign update_idx_o   = upd.idx;
    assign update_taken_o = upd.taken;

    assign redirect_o    = mispredict;
    assign redirect_pc_o = !valid_e  ? 32'h0 :
                           taken_e_i ? pc_target_e_i : pc_plus4_e;

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc     (resolve),
        .clr     (cnt_clr_i),
        .count   (branch_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_mispred_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc     (mispredict),
        .clr     (cnt_clr_i),
        .count   (mispred_cnt_o)
    );

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        stall_e_i, flush_e_i, branch_d_i, pred_taken_d_i;
    logic [7:0]  pred_idx_d_i;
    logic [31:0] pc_plus4_d_i;
    logic        taken_e_i;
    logic [31:0] pc_target_e_i;
    logic        cnt_clr_i;

    logic        redirect_o, update_en_o, update_taken_o;
    logic [31:0] redirect_pc_o;
    logic [7:0]  update_idx_o;
    logic [31:0] branch_cnt_o, mispred_cnt_o;

    // Narrow-counter instance for saturation; shares all inputs.
    logic        redirect4, update_en4, update_taken4;
    logic [31:0] redirect_pc4;
    logic [7:0]  update_idx4;
    logic [3:0]  branch_cnt4, mispred_cnt4;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    branch_resolver #(.IDX_W(8), .CNT_W(32)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .stall_e_i(stall_e_i), .flush_e_i(flush_e_i),
        .branch_d_i(branch_d_i), .pred_taken_d_i(pred_taken_d_i), .pred_idx_d_i(pred_idx_d_i),
        .pc_plus4_d_i(pc_plus4_d_i), .taken_e_i(taken_e_i), .pc_target_e_i(pc_target_e_i),
        .cnt_clr_i(cnt_clr_i), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .update_en_o(update_en_o), .update_idx_o(update_idx_o), .update_taken_o(update_taken_o),
        .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
    );

    branch_resolver #(.IDX_W(8), .CNT_W(4)) dut4 (
        .clk_i(clk_i), .reset_i(reset_i), .stall_e_i(stall_e_i), .flush_e_i(flush_e_i),
        .branch_d_i(branch_d_i), .pred_taken_d_i(pred_taken_d_i), .pred_idx_d_i(pred_idx_d_i),
        .pc_plus4_d_i(pc_plus4_d_i), .taken_e_i(taken_e_i), .pc_target_e_i(pc_target_e_i),
        .cnt_clr_i(cnt_clr_i), .redirect_o(redirect4), .redirect_pc_o(redirect_pc4),
        .update_en_o(update_en4), .update_idx_o(update_idx4), .update_taken_o(update_taken4),
        .branch_cnt_o(branch_cnt4), .mispred_cnt_o(mispred_cnt4)
    );

    typedef struct {
        logic        stall, flush, br, pred;
        logic [7:0]  idx;
        logic [31:0] pc4;
        logic        taken;
        logic [31:0] tgt;
        logic        clr;
        logic        e_en;
        logic [7:0]  e_idx;
        logic        e_ut, e_rd;
        logic [31:0] e_rpc, e_bc, e_mc;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(
        input logic br, input logic pred, input logic [7:0] idx, input logic [31:0] pc4,
        input logic taken, input logic [31:0] tgt, input logic clr,
        input logic e_en, input logic [7:0] e_idx, input logic e_ut, input logic e_rd,
        input logic [31:0] e_rpc, input logic [31:0] e_bc, input logic [31:0] e_mc);
        vec_t v;
        v.stall = 1'b0; v.flush = 1'b0;
        v.br = br; v.pred = pred; v.idx = idx; v.pc4 = pc4;
        v.taken = taken; v.tgt = tgt; v.clr = clr;
        v.e_en = e_en; v.e_idx = e_idx; v.e_ut = e_ut; v.e_rd = e_rd;
        v.e_rpc = e_rpc; v.e_bc = e_bc; v.e_mc = e_mc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_d(input logic br, input logic pred, input logic [7:0] idx,
                           input logic [31:0] pc4);
        branch_d_i = br; pred_taken_d_i = pred; pred_idx_d_i = idx; pc_plus4_d_i = pc4;
    endtask

    initial begin
        reset_i = 1'b1;
        stall_e_i = 0; flush_e_i = 0; cnt_clr_i = 0;
        drive_d(1'b1, 1'b1, 8'hAB, 32'h1234);
        taken_e_i = 1'b1; pc_target_e_i = 32'hDEAD_BEEF;

        // Reset state: all outputs 0 even with live inputs.
        #12;
        chk("rst_update_en", {31'b0, update_en_o}, 0);
        chk("rst_redirect", {31'b0, redirect_o}, 0);
        chk("rst_redirect_pc", redirect_pc_o, 0);
        chk("rst_update_idx", {24'b0, update_idx_o}, 0);
        chk("rst_update_taken", {31'b0, update_taken_o}, 0);
        chk("rst_branch_cnt", branch_cnt_o, 0);
        chk("rst_mispred_cnt", mispred_cnt_o, 0);

        drive_d(1'b0, 1'b0, 8'h00, 32'h0);
        taken_e_i = 1'b0; pc_target_e_i = 32'h0;
        @(negedge clk_i);
        reset_i = 1'b0;
        tick();

        //            br pred idx    pc4         tk tgt          clr en idx   ut rd rpc          bc mc
        vecs[0] = mk(1, 1, 8'h2A, 32'h104, 0, 32'h0,     0, 0, 8'h00, 0, 0, 32'h0,     0, 0);
        vecs[1] = mk(1, 1, 8'h11, 32'h208, 1, 32'h500,   0, 1, 8'h2A, 1, 0, 32'h500,   1, 0);
        vecs[2] = mk(1, 0, 8'h33, 32'h30C, 0, 32'h300,   0, 1, 8'h11, 0, 1, 32'h208,   2, 1);
        vecs[3] = mk(0, 1, 8'h44, 32'h50,  1, 32'h400,   0, 1, 8'h33, 1, 1, 32'h400,   3, 2);
        vecs[4] = mk(1, 0, 8'h55, 32'h704, 1, 32'h600,   0, 0, 8'h44, 0, 0, 32'h0,     3, 2);
        vecs[5] = mk(1, 1, 8'h66, 32'h804, 0, 32'h900,   1, 1, 8'h55, 0, 0, 32'h704,   0, 0);
        vecs[6] = mk(0, 0, 8'h00, 32'h0,   1, 32'hA00,   0, 1, 8'h66, 1, 0, 32'hA00,   1, 0);
        vecs[7] = mk(0, 0, 8'h00, 32'h0,   0, 32'h0,     0, 0, 8'h00, 0, 0, 32'h0,     1, 0);

        for (int i = 0; i < 8; i++) begin
            stall_e_i = vecs[i].stall; flush_e_i = vecs[i].flush;
            drive_d(vecs[i].br, vecs[i].pred, vecs[i].idx, vecs[i].pc4);
            taken_e_i = vecs[i].taken; pc_target_e_i = vecs[i].tgt; cnt_clr_i = vecs[i].clr;
            #1;
            chk($sformatf("v%0d_update_en", i), {31'b0, update_en_o}, {31'b0, vecs[i].e_en});
            chk($sformatf("v%0d_update_idx", i), {24'b0, update_idx_o}, {24'b0, vecs[i].e_idx});
            chk($sformatf("v%0d_update_taken", i), {31'b0, update_taken_o}, {31'b0, vecs[i].e_ut});
            chk($sformatf("v%0d_redirect", i), {31'b0, redirect_o}, {31'b0, vecs[i].e_rd});
            chk($sformatf("v%0d_redirect_pc", i), redirect_pc_o, vecs[i].e_rpc);
            tick();
            chk($sformatf("v%0d_branch_cnt", i), branch_cnt_o, vecs[i].e_bc);
            chk($sformatf("v%0d_mispred_cnt", i), mispred_cnt_o, vecs[i].e_mc);
        end
        cnt_clr_i = 0;

        // Stall a mispredicting branch for 3 cycles: no strobe until it leaves.
        drive_d(1'b1, 1'b1, 8'h77, 32'h1000);
        tick();
        drive_d(1'b1, 1'b0, 8'h12, 32'h2222);
        taken_e_i = 1'b0; pc_target_e_i = 32'h2000; stall_e_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_update_en", c), {31'b0, update_en_o}, 0);
            chk($sformatf("stall%0d_redirect", c), {31'b0, redirect_o}, 0);
            chk($sformatf("stall%0d_redirect_pc", c), redirect_pc_o, 32'h1000);
            tick();
        end
        stall_e_i = 1'b0; drive_d(1'b0, 1'b0, 8'h00, 32'h0);
        #1;
        chk("unstall_update_en", {31'b0, update_en_o}, 1);
        chk("unstall_update_idx", {24'b0, update_idx_o}, 8'h77);
        chk("unstall_redirect", {31'b0, redirect_o}, 1);
        tick();
        chk("unstall_branch_cnt", branch_cnt_o, 2);
        chk("unstall_mispred_cnt", mispred_cnt_o, 1);
        chk("after_unstall_update_en", {31'b0, update_en_o}, 0);

        // Flush and stall together at load: flush wins, nothing to resolve.
        drive_d(1'b1, 1'b1, 8'h22, 32'h3000);
        flush_e_i = 1'b1; stall_e_i = 1'b1;
        tick();
        flush_e_i = 1'b0; stall_e_i = 1'b0; drive_d(1'b0, 1'b0, 8'h00, 32'h0);
        #1;
        chk("flushstall_update_en", {31'b0, update_en_o}, 0);
        tick();

        // Flush does not stop the branch already in Execute from resolving.
        drive_d(1'b1, 1'b0, 8'h5A, 32'h3100);
        tick();
        drive_d(1'b1, 1'b1, 8'h5B, 32'h3200);
        flush_e_i = 1'b1; taken_e_i = 1'b0;
        #1;
        chk("flush_resolve_en", {31'b0, update_en_o}, 1);
        chk("flush_resolve_idx", {24'b0, update_idx_o}, 8'h5A);
        tick();
        flush_e_i = 1'b0; drive_d(1'b0, 1'b0, 8'h00, 32'h0);
        #1;
        chk("flushed_bubble_en", {31'b0, update_en_o}, 0);
        chk("flush_branch_cnt", branch_cnt_o, 3);

        // Saturation: clear, then 17 resolved mispredicts.
        cnt_clr_i = 1'b1;
        tick();
        cnt_clr_i = 1'b0;
        drive_d(1'b1, 1'b1, 8'h09, 32'h10);
        taken_e_i = 1'b0; pc_target_e_i = 32'h20;
        for (int i = 0; i < 18; i++) begin
            if (i == 17) branch_d_i = 1'b0;
            tick();
        end
        chk("sat4_branch_cnt", {28'b0, branch_cnt4}, 32'hF);
        chk("sat4_mispred_cnt", {28'b0, mispred_cnt4}, 32'hF);
        chk("sat32_branch_cnt", branch_cnt_o, 17);
        chk("sat32_mispred_cnt", mispred_cnt_o, 17);

        // Clear coinciding with a resolve: clear wins.
        drive_d(1'b1, 1'b1, 8'h0A, 32'h10);
        tick();
        drive_d(1'b0, 1'b0, 8'h00, 32'h0);
        cnt_clr_i = 1'b1;
        #1;
        chk("clr_resolve_en", {31'b0, update_en_o}, 1);
        tick();
        cnt_clr_i = 1'b0;
        chk("clr4_branch_cnt", {28'b0, branch_cnt4}, 0);
        chk("clr4_mispred_cnt", {28'b0, mispred_cnt4}, 0);
        chk("clr32_branch_cnt", branch_cnt_o, 0);
        chk("clr32_mispred_cnt", mispred_cnt_o, 0);

        // Async reset mid-cycle with a branch in Execute.
        drive_d(1'b1, 1'b1, 8'h3C, 32'h40);
        taken_e_i = 1'b0; pc_target_e_i = 32'h80;
        tick();
        tick();
        chk("prerst_branch_cnt", branch_cnt_o, 1);
        chk("prerst_update_en", {31'b0, update_en_o}, 1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("arst_update_en", {31'b0, update_en_o}, 0);
        chk("arst_redirect", {31'b0, redirect_o}, 0);
        chk("arst_redirect_pc", redirect_pc_o, 0);
        chk("arst_branch_cnt", branch_cnt_o, 0);
        chk("arst_mispred_cnt", mispred_cnt_o, 0);
        drive_d(1'b0, 1'b0, 8'h00, 32'h0);
        tick();
        reset_i = 1'b0;
        tick();
        chk("postrst_update_en", {31'b0, update_en_o}, 0);
        chk("postrst_branch_cnt", branch_cnt_o, 0);
        drive_d(1'b1, 1'b0, 8'h4D, 32'h90);
        taken_e_i = 1'b0;
        tick();
        drive_d(1'b0, 1'b0, 8'h00, 32'h0);
        #1;
        chk("newload_update_en", {31'b0, update_en_o}, 1);
        chk("newload_update_idx", {24'b0, update_idx_o}, 8'h4D);
        chk("newload_redirect", {31'b0, redirect_o}, 0);
        tick();
        chk("newload_branch_cnt", branch_cnt_o, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
